// File: rtl/vx_dp_ram_pipe_pkg.sv
// Shared types and helpers for the pipelined simple-dual-port RAM.
package vx_dp_ram_pipe_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int MAX_LANEW = 256;

  // Width of one write lane.
  function automatic int calc_wselw(input int dataw, input int wrenw);
    return dataw / wrenw;
  endfunction

  // Even parity of one lane: XOR-reduce of its (zero-extended) bits.
  function automatic logic lane_parity(input logic [MAX_LANEW-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/vx_dp_ram_pipe_skid.sv
// Two-entry response FIFO. The head is always a register so the consumer
// never sees array read timing, and in_ready depends only on local state.
module vx_dp_ram_pipe_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry storage and occupancy; head always holds the oldest response.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Push and pop together only happen with one entry held.
        2'b11:   head_q <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_dp_ram_pipe.sv
// Simple-dual-port RAM with valid/ready write, read-request and read-response
// channels, write-first forwarding, 2-entry response buffer and post-reset
// clear sweep. Optional per-lane parity: define VX_DP_RAM_PIPE_PARITY_EN.
module vx_dp_ram_pipe
  import vx_dp_ram_pipe_pkg::*;
#(
  parameter  int               DATAW      = 32,
  parameter  int               SIZE       = 64,
  parameter  int               WRENW      = 4,
  parameter  int               INIT_CLEAR = 1,
  parameter  logic [DATAW-1:0] INIT_VALUE = '0,
  localparam int               ADDRW      = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             init_done,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [WRENW-1:0] wr_byteen,
  input  logic [DATAW-1:0] wr_data,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [ADDRW-1:0] rd_req_addr,
  output logic             rd_rsp_valid,
  input  logic             rd_rsp_ready,
`ifdef VX_DP_RAM_PIPE_PARITY_EN
  output logic [WRENW-1:0] rd_rsp_perr,
`endif
  output logic [DATAW-1:0] rd_rsp_data
);

  localparam int WSELW = calc_wselw(DATAW, WRENW);
`ifdef VX_DP_RAM_PIPE_PARITY_EN
  localparam int ROWW = DATAW + WRENW;  // {parity[WRENW], data[DATAW]}
`else
  localparam int ROWW = DATAW;
`endif
  localparam logic [ADDRW-1:0] LAST_ROW = ADDRW'(SIZE - 1);
  localparam logic [ADDRW:0]   SIZE_EXT = (ADDRW + 1)'(SIZE);

  if (DATAW % WRENW != 0) begin : g_bad_lanes
    $error("vx_dp_ram_pipe: DATAW must be a multiple of WRENW");
  end
  if (WSELW > MAX_LANEW) begin : g_bad_lanew
    $error("vx_dp_ram_pipe: lane width exceeds MAX_LANEW");
  end

  state_e           state_q, state_d;
  logic [ADDRW-1:0] clr_q, clr_d;
  logic [WRENW-1:0] mem_we;
  logic [ADDRW-1:0] mem_waddr;
  logic [DATAW-1:0] mem_wdata;
  logic             wr_fire;
  logic             rd_fire;
  logic             skid_in_ready;
  logic [ROWW-1:0]  rd_merged;
  logic [ROWW-1:0]  skid_in;
  logic [ROWW-1:0]  skid_out;
  logic [ROWW-1:0]  mem [SIZE];

  assign init_done    = (state_q == ST_READY);
  assign wr_ready     = (state_q == ST_READY);
  assign rd_req_ready = (state_q == ST_READY) && skid_in_ready;
  assign wr_fire      = wr_valid && wr_ready;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  // Sweep state register; reset restarts the sweep from row 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Next state and array write-port mux: sweep owns the port during INIT.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    mem_we    = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      ST_INIT: begin
        mem_we    = '1;
        mem_waddr = clr_q;
        mem_wdata = INIT_VALUE;
        if (clr_q == LAST_ROW) state_d = ST_READY;
        else                   clr_d   = clr_q + ADDRW'(1);
      end
      ST_READY: begin
        if (wr_valid) mem_we = wr_byteen;
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef VX_DP_RAM_PIPE_PARITY_EN
  logic [WRENW-1:0] wpar;
  logic [WRENW-1:0] rd_perr;

  function automatic logic lane_par(input logic [WSELW-1:0] v);
    logic [MAX_LANEW-1:0] e;
    e            = '0;
    e[WSELW-1:0] = v;
    return lane_parity(e);
  endfunction

  // Parity of each lane of the data about to be written.
  always_comb begin
    wpar = '0;
    for (int i = 0; i < WRENW; i++) wpar[i] = lane_par(mem_wdata[i*WSELW +: WSELW]);
  end
`endif

  // Array write: enabled lanes only (and their parity bits when present).
  // NOTE: the array has no reset; contents are defined only by the sweep.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRENW; i++) begin
      if (mem_we[i]) begin
        mem[mem_waddr][i*WSELW +: WSELW] <= mem_wdata[i*WSELW +: WSELW];
`ifdef VX_DP_RAM_PIPE_PARITY_EN
        mem[mem_waddr][DATAW+i] <= wpar[i];
`endif
      end
    end
  end

  // Read row with write-first forwarding per enabled lane on a same-row write.
  always_comb begin
    rd_merged = mem[rd_req_addr];
    for (int i = 0; i < WRENW; i++) begin
      if (wr_fire && (wr_addr == rd_req_addr) && wr_byteen[i]) begin
        rd_merged[i*WSELW +: WSELW] = wr_data[i*WSELW +: WSELW];
`ifdef VX_DP_RAM_PIPE_PARITY_EN
        rd_merged[DATAW+i] = wpar[i];
`endif
      end
    end
`ifdef VX_DP_RAM_PIPE_PARITY_EN
    rd_perr = '0;
    for (int i = 0; i < WRENW; i++)
      rd_perr[i] = lane_par(rd_merged[i*WSELW +: WSELW]) ^ rd_merged[DATAW+i];
    skid_in = {rd_perr, rd_merged[DATAW-1:0]};
`else
    skid_in = rd_merged;
`endif
  end

  vx_dp_ram_pipe_skid #(
    .WIDTH(ROWW)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (rd_fire),
    .in_ready (skid_in_ready),
    .in_data  (skid_in),
    .out_valid(rd_rsp_valid),
    .out_ready(rd_rsp_ready),
    .out_data (skid_out)
  );

  assign rd_rsp_data = skid_out[DATAW-1:0];
`ifdef VX_DP_RAM_PIPE_PARITY_EN
  assign rd_rsp_perr = skid_out[DATAW +: WRENW];
`endif

  // Out-of-range addresses are illegal stimulus.
  a_wr_addr: assert property (@(posedge clk) disable iff (!reset_n)
    wr_fire |-> ({1'b0, wr_addr} < SIZE_EXT));
  a_rd_addr: assert property (@(posedge clk) disable iff (!reset_n)
    rd_fire |-> ({1'b0, rd_req_addr} < SIZE_EXT));

endmodule

// File: tb/tb_vx_dp_ram_pipe.sv
// Self-checking bench for vx_dp_ram_pipe: directed scenarios plus randomized
// traffic against a word-array / response-queue reference model.
module tb_vx_dp_ram_pipe;

  localparam int          DATAW = 32;
  localparam int          SIZE  = 64;
  localparam int          WRENW = 4;
  localparam int          ADDRW = 6;
  localparam logic [31:0] INITV = 32'hA5A5A5A5;

  logic             clk;
  logic             reset_n;
  logic             init_done;
  logic             wr_valid;
  logic             wr_ready;
  logic [ADDRW-1:0] wr_addr;
  logic [WRENW-1:0] wr_byteen;
  logic [DATAW-1:0] wr_data;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [ADDRW-1:0] rd_req_addr;
  logic             rd_rsp_valid;
  logic             rd_rsp_ready;
  logic [DATAW-1:0] rd_rsp_data;
  logic [WRENW-1:0] rd_rsp_perr;

  vx_dp_ram_pipe #(
    .DATAW(DATAW), .SIZE(SIZE), .WRENW(WRENW), .INIT_CLEAR(1), .INIT_VALUE(INITV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_byteen(wr_byteen), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
`ifdef VX_DP_RAM_PIPE_PARITY_EN
    .rd_rsp_perr(rd_rsp_perr),
`endif
    .rd_rsp_data(rd_rsp_data)
  );

`ifndef VX_DP_RAM_PIPE_PARITY_EN
  assign rd_rsp_perr = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: word contents, lanes with corrupted parity, pending responses.
  typedef struct packed {
    logic [WRENW-1:0] perr;
    logic [DATAW-1:0] data;
  } rsp_t;

  logic [DATAW-1:0] model_mem  [SIZE];
  logic [WRENW-1:0] model_pbad [SIZE];
  rsp_t             exp_q[$];
  bit               model_ready;

  int n_tests;
  int n_fail;

  // Observations from the most recent step().
  logic             obs_valid, exp_valid, obs_rready, exp_rready, rd_acc;
  logic [DATAW-1:0] head_got, head_exp;
  logic [WRENW-1:0] perr_got, perr_exp;

  task automatic model_clear();
    for (int r = 0; r < SIZE; r++) begin
      model_mem[r]  = INITV;
      model_pbad[r] = '0;
    end
    exp_q.delete();
  endtask

  // One clock: sample at negedge, advance the model, return at posedge+1.
  task automatic step();
    rsp_t e;
    @(negedge clk);
    obs_valid  = rd_rsp_valid;
    exp_valid  = (exp_q.size() != 0);
    obs_rready = rd_req_ready;
    exp_rready = model_ready && (exp_q.size() < 2);
    head_got   = rd_rsp_data;
    perr_got   = rd_rsp_perr;
    head_exp   = exp_valid ? exp_q[0].data : '0;
    perr_exp   = exp_valid ? exp_q[0].perr : '0;
    if (exp_valid && rd_rsp_ready) void'(exp_q.pop_front());
    rd_acc = rd_req_valid && exp_rready;
    if (rd_acc) begin
      e.data = model_mem[rd_req_addr];
      e.perr = model_pbad[rd_req_addr];
      if (wr_valid && model_ready && wr_addr == rd_req_addr)
        for (int i = 0; i < WRENW; i++)
          if (wr_byteen[i]) begin
            e.data[i*8 +: 8] = wr_data[i*8 +: 8];
            e.perr[i]        = 1'b0;
          end
      exp_q.push_back(e);
    end
    if (wr_valid && model_ready)
      for (int i = 0; i < WRENW; i++)
        if (wr_byteen[i]) begin
          model_mem[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
          model_pbad[wr_addr][i]       = 1'b0;
        end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_byteen    = '0;
    wr_data      = '0;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
  endtask

  task automatic issue_write(input logic [ADDRW-1:0] a, input logic [WRENW-1:0] be,
                             input logic [DATAW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_byteen = be; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic issue_read(input logic [ADDRW-1:0] a);
    rd_req_valid = 1'b1; rd_req_addr = a;
    step();
    rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    rd_rsp_ready = 1'b1;
    repeat (3) step();
  endtask

  // After reset release: posedges until init_done, flag early readiness.
  task automatic wait_sweep(output int cycles, output bit early);
    cycles = -1;
    early  = 1'b0;
    for (int c = 1; c <= 2 * SIZE; c++) begin
      @(posedge clk);
      #1;
      if (init_done === 1'b1) begin
        cycles = c;
        break;
      end
      if (wr_ready !== 1'b0 || rd_req_ready !== 1'b0) early = 1'b1;
    end
    model_ready = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    int cyc;
    bit early;
    logic [DATAW-1:0] rows [3];
    logic [ADDRW-1:0] addrs [3];
    reset_n = 1'b0; rd_rsp_ready = 1'b0; model_ready = 1'b0;
    idle_inputs();
    #3;
    n_tests++;
    if ({init_done, wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b wr_rdy=%b rq_rdy=%b vld=%b data=%h, expected all 0",
               init_done, wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_sweep(cyc, early);
    n_tests++;
    if (cyc != SIZE) begin
      n_fail++;
      $display("FAIL sweep_length: got %0d cycles, expected %0d", cyc, SIZE);
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL ready_during_sweep: got ready=1 before init_done, expected 0");
    end
    addrs = '{6'd0, 6'd31, 6'd63};
    rd_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue_read(addrs[k]);
      step();
      rows[k] = head_got;
      n_tests++;
      if (obs_valid !== 1'b1 || rows[k] !== INITV) begin
        n_fail++;
        $display("FAIL init_row%0d: got valid=%b data=%h, expected 1 %h",
                 addrs[k], obs_valid, rows[k], INITV);
      end
    end
  endtask

  task automatic test_byteen();
    rd_rsp_ready = 1'b1;
    issue_write(6'd5, 4'hF, 32'h11223344);
    issue_write(6'd5, 4'b0101, 32'hFFFFFFFF);
    issue_read(6'd5);
    step();
    n_tests++;
    if (obs_valid !== 1'b1 || head_got !== 32'h11FF33FF || perr_got !== 4'b0000) begin
      n_fail++;
      $display("FAIL byteen_merge: got valid=%b data=%h perr=%b, expected 1 11ff33ff 0000",
               obs_valid, head_got, perr_got);
    end
  endtask

  task automatic test_same_edge();
    rd_rsp_ready = 1'b1;
    issue_write(6'd9, 4'hF, 32'h00000000);
    wr_valid = 1'b1; wr_addr = 6'd9; wr_byteen = 4'b1100; wr_data = 32'hDEADBEEF;
    rd_req_valid = 1'b1; rd_req_addr = 6'd9;
    step();
    idle_inputs();
    step();
    n_tests++;
    if (obs_valid !== 1'b1 || head_got !== 32'hDEAD0000) begin
      n_fail++;
      $display("FAIL write_first: got valid=%b data=%h, expected 1 dead0000", obs_valid, head_got);
    end
    issue_read(6'd9);
    step();
    n_tests++;
    if (head_got !== 32'hDEAD0000) begin
      n_fail++;
      $display("FAIL write_first_stored: got %h, expected dead0000", head_got);
    end
  endtask

  task automatic test_backpressure();
    logic [DATAW-1:0] vals [3];
    logic [DATAW-1:0] got [$];
    bit bad_hold;
    vals = '{32'h01010101, 32'h02020202, 32'h03030303};
    rd_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) issue_write(ADDRW'(k + 1), 4'hF, vals[k]);
    rd_rsp_ready = 1'b0;
    issue_read(6'd1);
    issue_read(6'd2);
    rd_req_valid = 1'b1; rd_req_addr = 6'd3;
    bad_hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_rready !== 1'b0 || rd_acc || obs_valid !== 1'b1 || head_got !== vals[0])
        bad_hold = 1'b1;
    end
    n_tests++;
    if (bad_hold) begin
      n_fail++;
      $display("FAIL stall_hold: got rq_rdy=%b valid=%b data=%h, expected 0 1 %h",
               obs_rready, obs_valid, head_got, vals[0]);
    end
    rd_rsp_ready = 1'b1;
    for (int c = 0; c < 8 && got.size() < 3; c++) begin
      step();
      if (rd_acc) rd_req_valid = 1'b0;
      if (obs_valid === 1'b1) got.push_back(head_got);
    end
    n_tests++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL drain_count: got %0d responses, expected 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (got[k] !== vals[k]) begin
          n_fail++;
          $display("FAIL drain_order%0d: got %h, expected %h", k, got[k], vals[k]);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    int bad_v, bad_r, bad_d;
    bad_v = 0; bad_r = 0; bad_d = 0;
    for (int c = 0; c < 600; c++) begin
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_addr      = ADDRW'($urandom_range(0, 11));
      wr_byteen    = WRENW'($urandom_range(0, 15));
      wr_data      = $urandom;
      rd_req_valid = ($urandom_range(0, 2) != 0);
      rd_req_addr  = ADDRW'($urandom_range(0, 11));
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      n_tests += 3;
      if (obs_valid !== exp_valid) begin
        n_fail++; bad_v++;
        if (bad_v < 4) $display("FAIL rand_valid@%0d: got %b, expected %b", c, obs_valid, exp_valid);
      end
      if (obs_rready !== exp_rready) begin
        n_fail++; bad_r++;
        if (bad_r < 4) $display("FAIL rand_rq_ready@%0d: got %b, expected %b", c, obs_rready, exp_rready);
      end
      if (exp_valid && (head_got !== head_exp || perr_got !== perr_exp)) begin
        n_fail++; bad_d++;
        if (bad_d < 4) $display("FAIL rand_data@%0d: got %h/%b, expected %h/%b",
                                c, head_got, perr_got, head_exp, perr_exp);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit early;
    rd_rsp_ready = 1'b1;
    issue_write(6'd7, 4'hF, 32'h12345678);
    rd_rsp_ready = 1'b0;
    issue_read(6'd7);
    issue_read(6'd7);
    n_tests++;
    if (rd_rsp_valid !== 1'b1 || rd_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prefill_full: got valid=%b rq_rdy=%b, expected 1 0", rd_rsp_valid, rd_req_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (rd_rsp_valid !== 1'b0 || rd_rsp_data !== '0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b data=%h wr_rdy=%b, expected 0 0 0",
               rd_rsp_valid, rd_rsp_data, wr_ready);
    end
    model_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_sweep(cyc, early);
    n_tests++;
    if (cyc != SIZE || early) begin
      n_fail++;
      $display("FAIL sweep_restart: got %0d cycles early=%b, expected %0d 0", cyc, early, SIZE);
    end
    rd_rsp_ready = 1'b1;
    issue_read(6'd7);
    step();
    n_tests++;
    if (obs_valid !== 1'b1 || head_got !== INITV) begin
      n_fail++;
      $display("FAIL row_recleared: got valid=%b data=%h, expected 1 %h", obs_valid, head_got, INITV);
    end
  endtask

`ifdef VX_DP_RAM_PIPE_PARITY_EN
  task automatic test_parity();
    rd_rsp_ready = 1'b1;
    issue_write(6'd20, 4'hF, 32'h00000001);
    dut.mem[20][0] = ~dut.mem[20][0];
    model_mem[20][0]  = ~model_mem[20][0];
    model_pbad[20][0] = ~model_pbad[20][0];
    issue_read(6'd20);
    step();
    n_tests++;
    if (obs_valid !== 1'b1 || perr_got !== 4'b0001 || head_got !== 32'h00000000) begin
      n_fail++;
      $display("FAIL parity_error: got valid=%b perr=%b data=%h, expected 1 0001 00000000",
               obs_valid, perr_got, head_got);
    end
    issue_write(6'd20, 4'b0001, 32'h00000003);
    issue_read(6'd20);
    step();
    n_tests++;
    if (perr_got !== 4'b0000 || head_got !== 32'h00000003) begin
      n_fail++;
      $display("FAIL parity_rewrite: got perr=%b data=%h, expected 0000 00000003", perr_got, head_got);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_byteen();
    test_same_edge();
    test_backpressure();
    test_random();
`ifdef VX_DP_RAM_PIPE_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_dp_ram_pipe.md
Name: vx_dp_ram_pipe

Overview:
Simple-dual-port RAM with valid/ready handshakes on the write, read-request and read-response channels. Reads are registered and write-first forwarded; read data goes into a 2-entry response skid buffer. A post-reset clear sweep writes INIT_VALUE to every row. Drop-in replacement for raw RAM instances inside cache tag/data/MSHR stores wherever the consumer can stall.

Parameters:
DATAW, 32, word width in bits
SIZE, 64, number of rows (any value ≥2; need not be a power of two)
WRENW, 4, write-lane count; DATAW % WRENW == 0 (static assert); lane width WSELW = DATAW/WRENW
INIT_CLEAR, 1, 1 = run the clear sweep after reset; 0 = memory is ready immediately and contents are undefined
INIT_VALUE, 0, DATAW-bit value written by the clear sweep
ADDRW, LOG2UP(SIZE), address width (derived)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init_done  out  1  high once the clear sweep is complete
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDRW  write row
wr_byteen  in  WRENW  per-lane write enable
wr_data  in  DATAW  write data
rd_req_valid  in  1  read request
rd_req_ready  out  1  read request accepted when high
rd_req_addr  in  ADDRW  read row
rd_rsp_valid  out  1  response available
rd_rsp_ready  in  1  consumer accepts the response
rd_rsp_data  out  DATAW  response data

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: init_done=0, wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0.
  - FSM returns to INIT (or READY when INIT_CLEAR=0).
  - Response buffer count is cleared. RAM contents are not reset.
- FSM states: INIT and READY.
  - INIT: a clear counter runs 0..SIZE-1, writing INIT_VALUE to all lanes, one row per clock.
  - INIT→READY on the cycle after row SIZE-1 is written; the sweep takes exactly SIZE cycles after reset release.
  - READY is absorbing until the next reset.
  - Reset asserted mid-sweep restarts the sweep at row 0.
- wr_ready = (state==READY). A write is accepted at the posedge where wr_valid && wr_ready; only lanes with wr_byteen[i]=1 are updated. wr_byteen=0 is a legal no-op.
- rd_req_ready = (state==READY) && (count<2). There is no combinational path from rd_rsp_ready to rd_req_ready.
- Read timing: an accepted request at edge N reads the array synchronously and pushes the data into the response FIFO at edge N. rd_rsp_valid is high after edge N (latency 1).
- Same-edge read and write: for a write accepted at the same edge to the same row, enabled lanes return the new wr_data and disabled lanes return old contents (write-first, per lane).
- Response FIFO: depth 2, FIFO order.
  - Pop when rd_rsp_valid && rd_rsp_ready.
  - Simultaneous push and pop keeps count unchanged.
  - rd_rsp_data and rd_rsp_valid are held stable while rd_rsp_valid && !rd_rsp_ready.
  - The head is driven from a register, not directly from the array.
  - With rd_rsp_ready held high, throughput is 1 read per cycle.
- Illegal stimulus: address ≥ SIZE triggers an assertion in simulation; the result is undefined in synthesis.

Optional Feature:
VX_DP_RAM_PIPE_PARITY_EN
- Defined:
  - Each row stores one extra even-parity bit per lane, computed on write. For lanes with wr_byteen=0, the parity bit is recomputed only for the enabled lanes.
  - A new output rd_rsp_perr (WRENW bits) travels with rd_rsp_data through the FIFO. Bit i = parity mismatch on lane i.
  - rd_rsp_perr resets to 0. The clear sweep writes correct parity.
- Undefined: no parity storage and no rd_rsp_perr port.

Decomposition:
- Package vx_dp_ram_pipe_pkg:
  - state enum (INIT, READY)
  - WSELW calc
  - parity function (per-lane XOR reduce)
- One sub-module, vx_dp_ram_pipe_skid: the 2-entry response FIFO, parameterised by width (DATAW, or DATAW+WRENW with parity).
- The array, write-first merge and FSM stay in the top module.

Test Plan:
1. SIZE=64, INIT_CLEAR=1, INIT_VALUE=32'hA5A5A5A5; release reset → init_done rises exactly 64 cycles later; wr_ready/rd_req_ready are 0 until then; reading rows 0, 31 and 63 returns A5A5A5A5.
2. Write row 5 = 32'h11223344 (byteen=4'hF), then write row 5 data 32'hFFFFFFFF with byteen=4'b0101 → read row 5 returns 32'h11FF33FF.
3. Same edge: write row 9 = 32'hDEADBEEF byteen=4'b1100 and read row 9 (old value 0) → response 32'hDEAD0000 one cycle later.
4. Hold rd_rsp_ready=0 and issue reads to rows 1, 2, 3 → rd_req_ready drops after 2 accepts; data stays at row 1's value. Raise ready → rows 1, 2, then 3 (3 is accepted once count<2), in order.
5. Assert reset_n=0 while count=2 and the sweep is mid-way (rerun with INIT_CLEAR=1, reset at cycle 20 of the sweep) → rd_rsp_valid=0 immediately and asynchronously; the sweep restarts and init_done takes a full 64 cycles.
6. Parity macro defined: write 32'h00000001, force-flip bit 0 of the array via backdoor, read → rd_rsp_perr=4'b0001.
